// File: rtl/i2c_controller.sv
// I2C bus initiator: START, address+R/W, multi-byte write or read, STOP on open-drain SCL/SDA.
// Bit timing is divided into four quarters of CLK_DIV cycles each; SCL is low for q0-q1.
module i2c_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [3:0] cmd_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       nack,
  output logic       scl_out,
  output logic       sda_out,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       quarter_q, quarter_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       remaining_q, remaining_d;
  logic             rw_q, rw_d;
  logic             ack_q, ack_d;
  logic             nack_q, nack_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic load_slot;
  logic stall;
  logic tick;
  logic sample;
  logic period_end;

  // The write byte is fetched on the first cycle of bit 7; the bit clock freezes there until it arrives.
  assign load_slot  = (state_q == WRITE) && (bit_q == 3'd7) && (quarter_q == 2'd0) &&
                      (div_q == '0);
  assign stall      = load_slot && !wr_valid;
  assign tick       = !stall && (div_q == DIV_LAST);
  assign sample     = tick && (quarter_q == 2'd2);
  assign period_end = tick && (quarter_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    quarter_d   = quarter_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    nack_d      = nack_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;

    if (state_q != IDLE && !stall) begin
      div_d     = tick ? '0 : div_q + DIV_W'(1);
      quarter_d = tick ? quarter_q + 2'd1 : quarter_q;
    end

    if (load_slot && wr_valid) begin
      shift_d = wr_data;
    end

    if (sample) begin
      ack_d = sda_in;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d     = START;
          shift_d     = {cmd_addr, cmd_rw};
          rw_d        = cmd_rw;
          remaining_d = cmd_len;
          nack_d      = 1'b0;
          bit_d       = 3'd7;
          div_d       = '0;
          quarter_d   = 2'd0;
        end
      end
      START: begin
        if (period_end) begin
          state_d = ADDR;
        end
      end
      ADDR, WRITE: begin
        if (period_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          if (bit_q == 3'd0) begin
            state_d = (state_q == ADDR) ? ADDR_ACK : WRITE_ACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ADDR_ACK: begin
        if (period_end) begin
          bit_d = 3'd7;
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else if (remaining_q == 4'd0) begin
            state_d = STOP;
          end else if (rw_q) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE_ACK: begin
        if (period_end) begin
          bit_d = 3'd7;
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else begin
            remaining_d = remaining_q - 4'd1;
            state_d     = (remaining_q == 4'd1) ? STOP : WRITE;
          end
        end
      end
      READ: begin
        if (sample) begin
          shift_d = {shift_q[6:0], sda_in};
          if (bit_q == 3'd0) begin
            rd_data_d  = {shift_q[6:0], sda_in};
            rd_valid_d = 1'b1;
          end
        end
        if (period_end) begin
          if (bit_q == 3'd0) begin
            state_d = READ_ACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      READ_ACK: begin
        if (period_end) begin
          bit_d       = 3'd7;
          remaining_d = remaining_q - 4'd1;
          state_d     = (remaining_q == 4'd1) ? STOP : READ;
        end
      end
      STOP: begin
        if (period_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      quarter_q   <= 2'd0;
      bit_q       <= 3'd7;
      shift_q     <= 8'h00;
      remaining_q <= 4'd0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      nack_q      <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      quarter_q   <= quarter_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      nack_q      <= nack_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Bus levels decode directly from the registered state so a reset releases both lines at once.
  always_comb begin
    scl_out = 1'b1;
    sda_out = 1'b1;
    sda_oe  = 1'b0;
    case (state_q)
      START: begin
        if (quarter_q[1]) begin
          sda_oe  = 1'b1;
          sda_out = 1'b0;
        end
      end
      ADDR, WRITE: begin
        scl_out = quarter_q[1];
        sda_oe  = 1'b1;
        sda_out = shift_q[7];
      end
      ADDR_ACK, WRITE_ACK, READ: begin
        scl_out = quarter_q[1];
      end
      READ_ACK: begin
        scl_out = quarter_q[1];
        if (remaining_q > 4'd1) begin
          sda_oe  = 1'b1;
          sda_out = 1'b0;
        end
      end
      STOP: begin
        scl_out = quarter_q[1];
        if (quarter_q != 2'd3) begin
          sda_oe  = 1'b1;
          sda_out = 1'b0;
        end
      end
      default: begin
        scl_out = 1'b1;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wr_ready  = load_slot && wr_valid;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign nack      = nack_q;

endmodule

// File: doc/i2c_controller.md
# i2c_controller

I2C bus initiator clocked by `system_clk`. It issues START, address+R/W, multi-byte write or read, and STOP on an open-drain SCL/SDA pair. It is the counterpart to the design's SCL-clocked I2C peripheral and is used on-chip and in the bench to drive transactions at it. Commands arrive over a valid/ready handshake; write bytes stream in and read bytes stream out.

## Interface
- `CLK_DIV`, default 4: `system_clk` cycles per SCL quarter-period (min 1); bit period = 4*CLK_DIV cycles.
- `system_clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  controller idle; command accepted when both high
- `cmd_addr`  in  7  target address
- `cmd_rw`  in  1  1=read, 0=write
- `cmd_len`  in  4  byte count 0..15 (0 = address-only probe)
- `wr_data`  in  8  next write byte
- `wr_valid`  in  1  `wr_data` valid
- `wr_ready`  out  1  one-cycle pulse: `wr_data` captured
- `rd_data`  out  8  last byte read
- `rd_valid`  out  1  one-cycle pulse: `rd_data` updated
- `busy`  out  1  transaction in progress
- `nack`  out  1  target NACKed; sticky until next command accepted
- `scl_out`  out  1  SCL level (1 = released)
- `sda_out`  out  1  SDA drive value
- `sda_oe`  out  1  1 = drive `sda_out`, 0 = release
- `sda_in`  in  1  sampled SDA

## Operation
- Reset values: `cmd_ready`=1, `busy`=0, `nack`=0, `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `scl_out`=1, `sda_out`=1, `sda_oe`=0; state IDLE. Reset mid-transaction aborts it immediately. No STOP is generated.
- Command accept: latch addr/rw/len, clear `nack`, `cmd_ready`→0, `busy`→1. `cmd_valid` while busy is ignored.
- Each bit period has quarters q0..q3. SCL is low in q0–q1 and high in q2–q3. SDA is driven or released at the start of q0. `sda_in` is sampled on the last cycle of q2.
- IDLE → START: q0–q1 SDA released; q2–q3 SDA driven 0; SCL high throughout.
- ADDR: shift `{addr, rw}` MSB first, 8 bits.
- ADDR_ACK: release SDA and sample.
  - Sample 1: set `nack`, go to STOP.
  - Else len=0: STOP.
  - Else rw=1: READ.
  - Else: WRITE.
- WRITE: at q0 of bit 7, capture `wr_data` and pulse `wr_ready` if `wr_valid`. Otherwise hold q0 (SCL low, stall) until `wr_valid`. Then shift 8 bits MSB first.
- WRITE_ACK: release SDA and sample.
  - Sample 1: set `nack`, go to STOP.
  - Else decrement remaining count; 0 → STOP, else → WRITE.
- READ: release SDA and shift in 8 samples MSB first. After the 8th sample, update `rd_data` and pulse `rd_valid`.
- READ_ACK: drive 0 (ACK) if bytes remain, else release (NACK). Decrement count; 0 → STOP, else → READ.
- STOP: q0–q1 SCL low, SDA 0; q2 SCL high, SDA 0; q3 SCL high, SDA released → IDLE. `cmd_ready`=1 and `busy`=0 on the next cycle.
- SCL is never released-and-checked: target clock stretching and multi-master arbitration are not supported.
- The remaining-byte counter is 4 bits and never wraps, since it is checked for zero before each decrement.

## Timing
- Accept-to-idle (no NACK, no stall): 4*CLK_DIV*(2 + 9*(cmd_len+1)) cycles.
- Each `wr_valid` stall cycle adds exactly one cycle.
- NACK on any ACK slot: STOP follows immediately; remaining bytes are skipped. No further `wr_ready` or `rd_valid` pulses occur.
- `rd_valid` fires on the cycle after the q2 sample of bit 0, before that byte's ACK slot.
- `wr_ready` and `rd_valid` are never high in the same cycle.
- `cmd_valid` arriving the cycle `cmd_ready` rises is accepted that cycle. Back-to-back transactions are separated only by the STOP bit period.

## Test plan
- Write addr 0x71, len 2, data 0xA5, 0x3C, target ACKs (CLK_DIV=4):
  - SDA bytes 0xE2, 0xA5, 0x3C, each followed by a released ACK slot.
  - Exactly 2 `wr_ready` pulses; `nack`=0.
  - `cmd_ready` returns 464 cycles after accept.
- Read addr 0x2A, len 3, target returns 0x55, 0xAA, 0x0F:
  - Address byte 0x55.
  - 3 `rd_valid` pulses with those values.
  - Controller ACK slots are 0, 0, released.
- Address NACK: addr 0x10, `sda_in` held 1.
  - `nack`=1 after ADDR_ACK; STOP follows.
  - Zero `wr_ready` pulses; `nack` clears on the next accept.
- Write stall: `wr_valid` low for 50 cycles at byte 2.
  - `scl_out` held 0 for 50 extra cycles.
  - Byte contents intact; total time = nominal + 50.
- Reset asserted in WRITE bit 3.
  - Next cycle `scl_out`=1, `sda_oe`=0, `busy`=0, `cmd_ready`=1.
  - A new command then completes normally.
- Probe len 0 to addr 0x72 with ACK: START, address 0xE4, ACK, STOP; total 4*CLK_DIV*11 cycles.
